normalize_round_pack: RTL

//  Back end of the FPU add/sub path. Consumes the raw 28-bit magnitude and sign from the

---
 rtl/normalize_round_pack_if.sv | 30 +++
 rtl/normalize_round_pack.sv | 133 +++++++++++++
 2 files changed

// File: rtl/normalize_round_pack_if.sv
// Handshake bundle between the mantissa add/sub stage, the normalize/round/pack
// back end, and the result consumer.
interface normalize_round_pack_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int MANT_W = FRAC_W + 5;
  localparam int RES_W  = 1 + EXP_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mantisa_raw;
  logic              sign_result;
  logic [EXP_W-1:0]  exp_in;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  result;
  logic              overflow;
  logic              underflow;

  modport master (
    output in_valid, mantisa_raw, sign_result, exp_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, mantisa_raw, sign_result, exp_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/normalize_round_pack.sv
// FPU add/sub back end: iterative left-normalize, round-to-nearest-even and
// IEEE-754 pack, one operation in flight, valid/ready on both sides.
module normalize_round_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input logic                    clk,
  input logic                    rst,
  normalize_round_pack_if.slave  bus
);
  localparam int MANT_W = FRAC_W + 5;
  localparam int RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W:0] EXP_ONE = 1;
  localparam logic [EXP_W:0] EXP_TWO = 2;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, CHECK, NORM, ROUND, DONE} state_t;

  state_t            state, state_n;
  logic [MANT_W-1:0] m, m_n;
  logic [EXP_W:0]    e, e_n;
  logic              s, s_n;
  logic [RES_W-1:0]  result_q, result_n;
  logic              ovf_q, ovf_n;
  logic              unf_q, unf_n;
  logic              out_valid_q, out_valid_n;

  // Rounding datapath, only meaningful in ROUND
  logic              inc;
  logic [FRAC_W+1:0] sig;
  logic [FRAC_W:0]   sig_n;
  logic [EXP_W:0]    e_r;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

  always_comb begin
    inc   = m[2] & (m[1] | m[0] | m[3]);
    sig   = {1'b0, m[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, inc};
    sig_n = sig[FRAC_W+1] ? sig[FRAC_W+1:1] : sig[FRAC_W:0];
    e_r   = sig[FRAC_W+1] ? e + EXP_ONE : e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m           <= '0;
      e           <= '0;
      s           <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      m           <= m_n;
      e           <= e_n;
      s           <= s_n;
      result_q    <= result_n;
      ovf_q       <= ovf_n;
      unf_q       <= unf_n;
      out_valid_q <= out_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    m_n         = m;
    e_n         = e;
    s_n         = s;
    result_n    = result_q;
    ovf_n       = ovf_q;
    unf_n       = unf_q;
    out_valid_n = out_valid_q;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          m_n     = bus.mantisa_raw;
          e_n     = (bus.exp_in == '0) ? EXP_ONE : {1'b0, bus.exp_in};
          s_n     = bus.sign_result;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (m == '0) begin
          result_n = '0;
          state_n  = DONE;
        end else if (m[MANT_W-1]) begin
          m_n     = {1'b0, m[MANT_W-1:2], m[1] | m[0]};
          e_n     = e + EXP_ONE;
          state_n = ROUND;
        end else if (m[MANT_W-2] || e == EXP_ONE) begin
          // At the minimum exponent the value is already in subnormal form
          state_n = ROUND;
        end else begin
          state_n = NORM;
        end
      end
      NORM: begin
        m_n = m << 1;
        e_n = e - EXP_ONE;
        if (m[MANT_W-3] || e == EXP_TWO)
          state_n = ROUND;
      end
      ROUND: begin
        if (e_r >= EXP_MAX) begin
          result_n = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_n    = 1'b1;
        end else if (!sig_n[FRAC_W]) begin
          result_n = {s, {EXP_W{1'b0}}, sig_n[FRAC_W-1:0]};
          unf_n    = 1'b1;
        end else begin
          result_n = {s, e_r[EXP_W-1:0], sig_n[FRAC_W-1:0]};
        end
        state_n = DONE;
      end
      DONE: begin
        out_valid_n = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
